// File: rtl/rx_block_lock_if.sv
// Gearbox-side header stream into the block-lock controller and its status outputs.
interface rx_block_lock_if;
   logic [1:0] i_rx_header;
   logic       i_rx_header_valid;
   logic       i_rx_data_valid;
   logic       o_slip;
   logic       o_block_lock;
   logic       o_hi_ber;
   logic [7:0] o_ber_count;

   modport master (
      output i_rx_header, i_rx_header_valid, i_rx_data_valid,
      input  o_slip, o_block_lock, o_hi_ber, o_ber_count
   );

   modport slave (
      input  i_rx_header, i_rx_header_valid, i_rx_data_valid,
      output o_slip, o_block_lock, o_hi_ber, o_ber_count
   );
endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b receive block-lock FSM with gearbox slip control and a hi-BER monitor.
module rx_block_lock #(
   parameter int unsigned LOCK_HEADERS      = 64,
   parameter int unsigned LOCK_LOSS_INVALID = 16,
   parameter int unsigned SLIP_WAIT         = 32,
   parameter int unsigned BER_WINDOW        = 19531,
   parameter int unsigned BER_LIMIT         = 16
) (
   input  logic           i_rxc,
   input  logic           i_reset_n,
   rx_block_lock_if.slave rx
);

   localparam int unsigned SHW = $clog2(LOCK_HEADERS + 1);
   localparam int unsigned SIW = $clog2(LOCK_LOSS_INVALID + 1);
   localparam int unsigned WW  = $clog2(SLIP_WAIT + 1);
   localparam int unsigned BHW = $clog2(BER_WINDOW + 1);
   localparam int unsigned BIW = $clog2(BER_LIMIT + 1);

   localparam logic [SHW-1:0] SH_TERM   = SHW'(LOCK_HEADERS);
   localparam logic [SIW-1:0] INV_TERM  = SIW'(LOCK_LOSS_INVALID);
   localparam logic [WW-1:0]  WAIT_LOAD = WW'(SLIP_WAIT);
   localparam logic [WW-1:0]  WAIT_ONE  = WW'(1);
   localparam logic [BHW-1:0] BER_WIN   = BHW'(BER_WINDOW);
   localparam logic [BIW-1:0] BER_TERM  = BIW'(BER_LIMIT);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_WAIT,
      ST_LOCKED
   } state_e;

   state_e         state_q, state_d;
   logic [SHW-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
   logic [SIW-1:0] sh_inv_q, sh_inv_d, sh_inv_inc;
   logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BHW-1:0] ber_hdr_q, ber_hdr_d, ber_hdr_inc;
   logic [BIW-1:0] ber_inv_q, ber_inv_d, ber_inv_inc;
   logic [7:0]     ber_cnt_q, ber_cnt_d, ber_cnt_inc;
   logic           slip_q, slip_d;
   logic           lock_q, lock_d;
   logic           hi_ber_q, hi_ber_d;

   logic hdr_evt;
   logic hdr_bad;

   assign hdr_evt = rx.i_rx_header_valid & rx.i_rx_data_valid;
   assign hdr_bad = ~(rx.i_rx_header[1] ^ rx.i_rx_header[0]);

   always_ff @(posedge i_rxc or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_SEARCH;
         sh_cnt_q   <= '0;
         sh_inv_q   <= '0;
         wait_cnt_q <= '0;
         ber_hdr_q  <= '0;
         ber_inv_q  <= '0;
         ber_cnt_q  <= '0;
         slip_q     <= 1'b0;
         lock_q     <= 1'b0;
         hi_ber_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sh_cnt_q   <= sh_cnt_d;
         sh_inv_q   <= sh_inv_d;
         wait_cnt_q <= wait_cnt_d;
         ber_hdr_q  <= ber_hdr_d;
         ber_inv_q  <= ber_inv_d;
         ber_cnt_q  <= ber_cnt_d;
         slip_q     <= slip_d;
         lock_q     <= lock_d;
         hi_ber_q   <= hi_ber_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sh_cnt_d   = sh_cnt_q;
      sh_inv_d   = sh_inv_q;
      wait_cnt_d = wait_cnt_q;
      sh_cnt_inc = sh_cnt_q + SHW'(1);
      sh_inv_inc = sh_inv_q + SIW'(hdr_bad);
      unique case (state_q)
         ST_SEARCH: begin
            if (hdr_evt) begin
               if (hdr_bad) begin
                  state_d = ST_SLIP;
               end else if (sh_cnt_inc == SH_TERM) begin
                  state_d  = ST_LOCKED;
                  sh_cnt_d = '0;
                  sh_inv_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_inc;
               end
            end
         end
         ST_SLIP: begin
            state_d    = ST_WAIT;
            sh_cnt_d   = '0;
            sh_inv_d   = '0;
            wait_cnt_d = WAIT_LOAD;
         end
         ST_WAIT: begin
            // Leaving on the count of one makes the wait exactly SLIP_WAIT cycles.
            if (wait_cnt_q <= WAIT_ONE) begin
               state_d    = ST_SEARCH;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q - WW'(1);
            end
         end
         ST_LOCKED: begin
            if (hdr_evt) begin
               if (sh_inv_inc == INV_TERM) begin
                  state_d  = ST_SLIP;
                  sh_cnt_d = '0;
                  sh_inv_d = '0;
               end else if (sh_cnt_inc == SH_TERM) begin
                  sh_cnt_d = '0;
                  sh_inv_d = '0;
               end else begin
                  sh_cnt_d = sh_cnt_inc;
                  sh_inv_d = sh_inv_inc;
               end
            end
         end
         default: begin
            state_d = ST_SEARCH;
         end
      endcase
   end

   // ber_inv saturates at BER_LIMIT so "below limit" at window end is a simple compare.
   always_comb begin
      ber_hdr_d   = ber_hdr_q;
      ber_inv_d   = ber_inv_q;
      ber_cnt_d   = ber_cnt_q;
      hi_ber_d    = hi_ber_q;
      ber_hdr_inc = ber_hdr_q + BHW'(1);
      ber_inv_inc = (hdr_bad && (ber_inv_q != BER_TERM)) ? ber_inv_q + BIW'(1) : ber_inv_q;
      ber_cnt_inc = (hdr_bad && (ber_cnt_q != 8'hFF)) ? ber_cnt_q + 8'd1 : ber_cnt_q;
      if ((state_q != ST_LOCKED) || (state_d != ST_LOCKED)) begin
         ber_hdr_d = '0;
         ber_inv_d = '0;
         ber_cnt_d = '0;
         hi_ber_d  = 1'b0;
      end else if (hdr_evt) begin
         if (ber_inv_inc == BER_TERM) begin
            hi_ber_d = 1'b1;
         end
         if (ber_hdr_inc == BER_WIN) begin
            if (ber_inv_inc != BER_TERM) begin
               hi_ber_d = 1'b0;
            end
            ber_hdr_d = '0;
            ber_inv_d = '0;
            ber_cnt_d = '0;
         end else begin
            ber_hdr_d = ber_hdr_inc;
            ber_inv_d = ber_inv_inc;
            ber_cnt_d = ber_cnt_inc;
         end
      end
   end

   always_comb begin
      slip_d = (state_d == ST_SLIP);
      lock_d = (state_d == ST_LOCKED);
   end

   assign rx.o_slip       = slip_q;
   assign rx.o_block_lock = lock_q;
   assign rx.o_hi_ber     = hi_ber_q;
   assign rx.o_ber_count  = ber_cnt_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: default instance plus a short-BER-window instance.
module tb_rx_block_lock;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] hdr = 2'b00;
   logic       hv = 1'b0;
   logic       dv = 1'b0;

   int errors = 0;
   int checks = 0;
   int slips  = 0;

   always #5 clk = ~clk;

   rx_block_lock_if a_if ();
   rx_block_lock_if b_if ();

   assign a_if.i_rx_header       = hdr;
   assign a_if.i_rx_header_valid = hv;
   assign a_if.i_rx_data_valid   = dv;
   assign b_if.i_rx_header       = hdr;
   assign b_if.i_rx_header_valid = hv;
   assign b_if.i_rx_data_valid   = dv;

   rx_block_lock dut (
      .i_rxc     (clk),
      .i_reset_n (rst_n),
      .rx        (a_if.slave)
   );

   rx_block_lock #(
      .LOCK_HEADERS      (64),
      .LOCK_LOSS_INVALID (64),
      .SLIP_WAIT         (32),
      .BER_WINDOW        (100),
      .BER_LIMIT         (16)
   ) dut_ber (
      .i_rxc     (clk),
      .i_reset_n (rst_n),
      .rx        (b_if.slave)
   );

   always @(negedge clk) if (a_if.o_slip === 1'b1) slips++;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   task automatic tick(input logic [1:0] h, input logic v, input logic d);
      hdr = h;
      hv  = v;
      dv  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic valid_run(input int n);
      for (int i = 0; i < n; i++) tick(i[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
   endtask

   task automatic do_reset();
      hdr = 2'b00; hv = 1'b0; dv = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (a_if.o_slip !== 1'b0) begin errors++; $display("FAIL reset_slip: got %b expected 0", a_if.o_slip); end
      checks++; if (a_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", a_if.o_block_lock); end
      checks++; if (a_if.o_hi_ber !== 1'b0) begin errors++; $display("FAIL reset_hi_ber: got %b expected 0", a_if.o_hi_ber); end
      checks++; if (a_if.o_ber_count !== 8'd0) begin errors++; $display("FAIL reset_ber_count: got %0d expected 0", a_if.o_ber_count); end
      #2 rst_n = 1'b1;
   endtask

   task automatic test_lock_acquire();
      int s0;
      s0 = slips;
      for (int i = 0; i < 64; i++) begin
         tick(i[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
         if (i == 62) begin
            checks++; if (a_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL lock_early_63: got %b expected 0", a_if.o_block_lock); end
         end
         if (i == 63) begin
            checks++; if (a_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL lock_at_64: got %b expected 1", a_if.o_block_lock); end
         end
         tick(2'b11, 1'b1, 1'b0);
      end
      checks++; if (slips != s0) begin errors++; $display("FAIL acquire_no_slip: got %0d expected %0d", slips, s0); end
   endtask

   task automatic test_slip_wait();
      int s0;
      do_reset();
      s0 = slips;
      valid_run(9);
      tick(2'b11, 1'b1, 1'b1);
      checks++; if (a_if.o_slip !== 1'b1) begin errors++; $display("FAIL slip_pulse: got %b expected 1", a_if.o_slip); end
      checks++; if (a_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL slip_lock_low: got %b expected 0", a_if.o_block_lock); end
      tick(2'b00, 1'b1, 1'b1);
      checks++; if (a_if.o_slip !== 1'b0) begin errors++; $display("FAIL slip_one_cycle: got %b expected 0", a_if.o_slip); end
      for (int i = 0; i < 32; i++) begin
         if (i == 31 || (i % 3) == 0) tick(2'b11, 1'b1, 1'b1);
         else if ((i % 3) == 1)       tick(2'b00, 1'b1, 1'b1);
         else                         tick(2'b01, 1'b1, 1'b1);
      end
      checks++; if (slips != s0 + 1) begin errors++; $display("FAIL wait_ignores: got %0d expected %0d", slips, s0 + 1); end
      valid_run(63);
      checks++; if (a_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", a_if.o_block_lock); end
      valid_run(1);
      checks++; if (a_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL relock_64: got %b expected 1", a_if.o_block_lock); end
   endtask

   task automatic test_lock_loss();
      for (int i = 0; i < 64; i++) begin
         if ((i % 4) == 0 && i < 60) tick(2'b11, 1'b1, 1'b1);
         else                        tick(i[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
      end
      checks++; if (a_if.o_block_lock !== 1'b1 || a_if.o_slip !== 1'b0) begin errors++; $display("FAIL window_15_hold: got lock=%b slip=%b expected lock=1 slip=0", a_if.o_block_lock, a_if.o_slip); end
      for (int e = 1; e <= 40; e++) begin
         if (e >= 25) tick(2'b00, 1'b1, 1'b1);
         else         tick(e[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
         if (e == 39) begin
            checks++; if (a_if.o_block_lock !== 1'b1 || a_if.o_slip !== 1'b0) begin errors++; $display("FAIL loss_before_16: got lock=%b slip=%b expected lock=1 slip=0", a_if.o_block_lock, a_if.o_slip); end
         end
      end
      checks++; if (a_if.o_block_lock !== 1'b0 || a_if.o_slip !== 1'b1) begin errors++; $display("FAIL loss_at_16: got lock=%b slip=%b expected lock=0 slip=1", a_if.o_block_lock, a_if.o_slip); end
   endtask

   task automatic test_ber();
      do_reset();
      valid_run(64);
      checks++; if (b_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL ber_lock: got %b expected 1", b_if.o_block_lock); end
      for (int e = 1; e <= 100; e++) begin
         if ((e % 3) == 0 && e <= 48) tick(2'b11, 1'b1, 1'b1);
         else                         tick(e[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
         if (e == 47) begin
            checks++; if (b_if.o_hi_ber !== 1'b0 || b_if.o_ber_count !== 8'd15) begin errors++; $display("FAIL ber_15: got hi=%b cnt=%0d expected hi=0 cnt=15", b_if.o_hi_ber, b_if.o_ber_count); end
         end
         if (e == 48) begin
            checks++; if (b_if.o_hi_ber !== 1'b1 || b_if.o_ber_count !== 8'd16) begin errors++; $display("FAIL ber_16: got hi=%b cnt=%0d expected hi=1 cnt=16", b_if.o_hi_ber, b_if.o_ber_count); end
         end
         if (e == 99) begin
            checks++; if (b_if.o_hi_ber !== 1'b1 || b_if.o_ber_count !== 8'd16) begin errors++; $display("FAIL ber_w1_99: got hi=%b cnt=%0d expected hi=1 cnt=16", b_if.o_hi_ber, b_if.o_ber_count); end
         end
      end
      checks++; if (b_if.o_hi_ber !== 1'b1 || b_if.o_ber_count !== 8'd0) begin errors++; $display("FAIL ber_w1_end: got hi=%b cnt=%0d expected hi=1 cnt=0", b_if.o_hi_ber, b_if.o_ber_count); end
      for (int e = 1; e <= 100; e++) begin
         if (e == 10 || e == 20 || e == 30) tick(2'b00, 1'b1, 1'b1);
         else                               tick(e[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
         if (e == 30) begin
            checks++; if (b_if.o_hi_ber !== 1'b1 || b_if.o_ber_count !== 8'd3) begin errors++; $display("FAIL ber_w2_3: got hi=%b cnt=%0d expected hi=1 cnt=3", b_if.o_hi_ber, b_if.o_ber_count); end
         end
         if (e == 99) begin
            checks++; if (b_if.o_hi_ber !== 1'b1) begin errors++; $display("FAIL ber_w2_99: got hi=%b expected 1", b_if.o_hi_ber); end
         end
      end
      checks++; if (b_if.o_hi_ber !== 1'b0 || b_if.o_ber_count !== 8'd0 || b_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL ber_w2_end: got hi=%b cnt=%0d lock=%b expected hi=0 cnt=0 lock=1", b_if.o_hi_ber, b_if.o_ber_count, b_if.o_block_lock); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 16; i++) tick(2'b11, 1'b1, 1'b1);
      checks++; if (b_if.o_hi_ber !== 1'b1 || b_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL pre_reset_hi_ber: got hi=%b lock=%b expected hi=1 lock=1", b_if.o_hi_ber, b_if.o_block_lock); end
      hdr = 2'b00; hv = 1'b0; dv = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      checks++; if (b_if.o_hi_ber !== 1'b0 || b_if.o_block_lock !== 1'b0 || b_if.o_ber_count !== 8'd0 || b_if.o_slip !== 1'b0) begin errors++; $display("FAIL async_reset: got hi=%b lock=%b cnt=%0d slip=%b expected all 0", b_if.o_hi_ber, b_if.o_block_lock, b_if.o_ber_count, b_if.o_slip); end
      @(posedge clk);
      #3 rst_n = 1'b1;
      valid_run(63);
      checks++; if (b_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL async_relock_early: got %b expected 0", b_if.o_block_lock); end
      valid_run(1);
      checks++; if (b_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL async_relock_64: got %b expected 1", b_if.o_block_lock); end
   endtask

   task automatic test_ignore_no_data();
      int s0;
      do_reset();
      valid_run(30);
      s0 = slips;
      repeat (20) tick(2'b00, 1'b1, 1'b0);
      checks++; if (slips != s0) begin errors++; $display("FAIL ignore_no_slip: got %0d expected %0d", slips, s0); end
      valid_run(33);
      checks++; if (a_if.o_block_lock !== 1'b0) begin errors++; $display("FAIL ignore_count_63: got %b expected 0", a_if.o_block_lock); end
      valid_run(1);
      checks++; if (a_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL ignore_count_64: got %b expected 1", a_if.o_block_lock); end
   endtask

   task automatic test_loss_at_window_end();
      for (int e = 1; e <= 64; e++) begin
         if (e <= 15 || e == 64) tick(2'b11, 1'b1, 1'b1);
         else                    tick(e[0] ? 2'b10 : 2'b01, 1'b1, 1'b1);
         if (e == 63) begin
            checks++; if (a_if.o_block_lock !== 1'b1) begin errors++; $display("FAIL wend_before: got %b expected 1", a_if.o_block_lock); end
         end
      end
      checks++; if (a_if.o_block_lock !== 1'b0 || a_if.o_slip !== 1'b1) begin errors++; $display("FAIL wend_loss_wins: got lock=%b slip=%b expected lock=0 slip=1", a_if.o_block_lock, a_if.o_slip); end
   endtask

   initial begin
      test_reset();
      test_lock_acquire();
      test_slip_wait();
      test_lock_loss();
      test_ber();
      test_async_reset();
      test_ignore_no_data();
      test_loss_at_window_end();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
